// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and constants for the cache block fill controller.
package cache_fill_fsm_pkg;

  localparam int unsigned CNT_W             = 4;
  localparam int unsigned WORD_W            = 16;
  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned MEM_READ_LATENCY  = 4;
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'h000F;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_word_counter.sv
// Small word counter used to track issued and returned block words.
module fill_word_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc; clr restarts the count for a new block.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: pipelined 8-word block read from main memory.
module cache_fill_fsm #(
  parameter int unsigned ADDR_WIDTH      = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [15:0]           memory_data,
  input  logic                  memory_data_valid,
  output logic                  write_data_array,
  output logic [2:0]            data_word_sel,
  output logic [15:0]           data_out,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] fill_block_addr
);

  import cache_fill_fsm_pkg::*;

  fill_state_e      state_q;
  fill_state_e      state_d;
  logic             accept;
  logic             issue_inc;
  logic             ret_inc;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt;
  logic             issue_done;
  logic             last_word;

  assign issue_done = (issue_cnt == CNT_W'(WORDS_PER_BLOCK));
  assign last_word  = (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
  assign fsm_busy   = (state_q == FILL);
  assign mem_wr     = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Block base address captured when a miss is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_block_addr <= '0;
    end else if (accept) begin
      fill_block_addr <= miss_address & ~ADDR_WIDTH'(BLOCK_OFFSET_MASK);
    end
  end

  // Next state, read issue and array write decode.
  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    issue_inc        = 1'b0;
    ret_inc          = 1'b0;
    mem_enable       = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    data_word_sel    = 3'd0;
    data_out         = 16'h0000;
    write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          accept  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (!issue_done) begin
          mem_enable = 1'b1;
          mem_addr   = fill_block_addr + ADDR_WIDTH'({issue_cnt[2:0], 1'b0});
          issue_inc  = 1'b1;
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          data_word_sel    = ret_cnt[2:0];
          data_out         = memory_data;
          ret_inc          = 1'b1;
          if (last_word) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  fill_word_counter #(.W(CNT_W)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (issue_inc),
    .count (issue_cnt)
  );

  fill_word_counter #(.W(CNT_W)) u_ret_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (ret_inc),
    .count (ret_cnt)
  );

endmodule
